// File: rtl/md_pkg.sv
// md_pkg: opcode encoding, default latencies and counter width shared by the
// multiply/divide controller, its datapath and the bus interface.
package md_pkg;

  typedef logic [2:0] md_opcode_t;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_NOP   = 3'd7
  } md_op_e;

  localparam int MD_MUL_LAT_DEF = 5;
  localparam int MD_DIV_LAT_DEF = 10;
  localparam int MD_CNT_W       = 4;

  // True for the four opcodes that occupy the unit for several cycles.
  function automatic logic md_is_muldiv(input md_opcode_t op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // True for the two divide opcodes.
  function automatic logic md_is_div(input md_opcode_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_if.sv
// md_if: E/D-stage request side and HI/LO result side of the multiply/divide
// controller, bundled for the pipeline (master) and md_ctrl (slave).
//
// Handshake: start is a one-cycle valid with no ready. It may only be
// raised when the pipeline has honoured stall_req; a start seen while busy
// is dropped by the controller. stall_req is the back-pressure toward D.
interface md_if;
  import md_pkg::*;

  logic        start;
  md_opcode_t  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_md_use;
  logic        rd_sel;
  logic        busy;
  logic        stall_req;
  logic [31:0] hilo_out;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        dbg_state;  // 0 = IDLE, 1 = RUN

  modport master (
    output start, op, rs_val, rt_val, d_md_use, rd_sel,
    input  busy, stall_req, hilo_out, hi, lo, dbg_state
  );

  modport slave (
    input  start, op, rs_val, rt_val, d_md_use, rd_sel,
    output busy, stall_req, hilo_out, hi, lo, dbg_state
  );
endinterface

// File: rtl/md_calc.sv
// md_calc: combinational multiply/divide datapath. Produces the 64-bit
// {hi,lo} result for MULT/MULTU/DIV/DIVU and flags a divide by zero.
module md_calc
  import md_pkg::*;
(
  input  md_opcode_t  i_op,
  input  logic [31:0] i_rs_val,
  input  logic [31:0] i_rt_val,
  output logic [31:0] o_res_hi,
  output logic [31:0] o_res_lo,
  output logic        o_div_zero
);

  logic [63:0] w_a_sext;
  logic [63:0] w_b_sext;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_rt_zero;
  logic [31:0] w_udivisor;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic        w_rs_neg;
  logic        w_rt_neg;
  logic [31:0] w_rs_mag;
  logic [31:0] w_rt_mag;
  logic [31:0] w_sq_mag;
  logic [31:0] w_sr_mag;
  logic [31:0] w_sq;
  logic [31:0] w_sr;

  // Sign-extended 64-bit product gives the exact signed result mod 2^64.
  assign w_a_sext = {{32{i_rs_val[31]}}, i_rs_val};
  assign w_b_sext = {{32{i_rt_val[31]}}, i_rt_val};
  assign w_prod_s = w_a_sext * w_b_sext;
  assign w_prod_u = {32'd0, i_rs_val} * {32'd0, i_rt_val};

  // Divisor forced to 1 on zero so the datapath never divides by zero;
  // the result is discarded by the controller in that case.
  assign w_rt_zero  = (i_rt_val == 32'd0);
  assign w_udivisor = w_rt_zero ? 32'd1 : i_rt_val;
  assign w_uq       = i_rs_val / w_udivisor;
  assign w_ur       = i_rs_val % w_udivisor;

  // Signed divide on magnitudes: 0x80000000 negates to itself, which read
  // as unsigned is exactly 2^31, so the overflow case needs no special path.
  assign w_rs_neg = i_rs_val[31];
  assign w_rt_neg = i_rt_val[31];
  assign w_rs_mag = w_rs_neg ? (32'd0 - i_rs_val) : i_rs_val;
  assign w_rt_mag = w_rt_zero ? 32'd1 : (w_rt_neg ? (32'd0 - i_rt_val) : i_rt_val);
  assign w_sq_mag = w_rs_mag / w_rt_mag;
  assign w_sr_mag = w_rs_mag % w_rt_mag;
  assign w_sq     = (w_rs_neg ^ w_rt_neg) ? (32'd0 - w_sq_mag) : w_sq_mag;
  assign w_sr     = w_rs_neg ? (32'd0 - w_sr_mag) : w_sr_mag;

  // Select the result for the requested operation.
  always_comb begin
    o_res_hi   = 32'd0;
    o_res_lo   = 32'd0;
    o_div_zero = md_is_div(i_op) & w_rt_zero;
    case (i_op)
      MD_MULT:  {o_res_hi, o_res_lo} = w_prod_s;
      MD_MULTU: {o_res_hi, o_res_lo} = w_prod_u;
      MD_DIV:   begin o_res_hi = w_sr; o_res_lo = w_sq; end
      MD_DIVU:  begin o_res_hi = w_ur; o_res_lo = w_uq; end
      default:  begin o_res_hi = 32'd0; o_res_lo = 32'd0; end
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// md_ctrl: multiply/divide control and HI/LO ownership. A busy counter models
// the multi-cycle latency; the result computed at launch is held pending and
// committed to HI/LO on the edge the counter reaches zero.
// Optional build macro MDU_CANCEL_EN adds i_cancel to abort an operation.
module md_ctrl
  import md_pkg::*;
#(
  parameter int MUL_LAT = MD_MUL_LAT_DEF,
  parameter int DIV_LAT = MD_DIV_LAT_DEF
) (
  input  logic clk,
  input  logic rst,
  md_if.slave  bus
`ifdef MDU_CANCEL_EN
  ,
  input  logic i_cancel
`endif
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [MD_CNT_W-1:0] r_cnt;
  logic                r_busy;
  logic [31:0]         r_pend_hi;
  logic [31:0]         r_pend_lo;
  logic                r_pend_dz;
  logic [31:0]         r_hi;
  logic [31:0]         r_lo;

  logic                w_cancel;
  logic                w_idle;
  logic                w_accept;
  logic                w_launch;
  logic                w_commit;
  logic [MD_CNT_W-1:0] w_lat;
  logic [31:0]         w_res_hi;
  logic [31:0]         w_res_lo;
  logic                w_div_zero;
  logic [0:0]          w_state;

`ifdef MDU_CANCEL_EN
  assign w_cancel = i_cancel;
`else
  assign w_cancel = 1'b0;
`endif

  md_calc u_calc (
    .i_op       (bus.op),
    .i_rs_val   (bus.rs_val),
    .i_rt_val   (bus.rt_val),
    .o_res_hi   (w_res_hi),
    .o_res_lo   (w_res_lo),
    .o_div_zero (w_div_zero)
  );

  assign w_idle   = (r_cnt == '0);
  assign w_state  = w_idle ? ST_IDLE : ST_RUN;
  assign w_accept = bus.start & w_idle & ~w_cancel;
  assign w_launch = w_accept & md_is_muldiv(bus.op);
  assign w_commit = (r_cnt == MD_CNT_W'(1)) & ~w_cancel;
  assign w_lat    = md_is_div(bus.op) ? MD_CNT_W'(DIV_LAT) : MD_CNT_W'(MUL_LAT);

  // Latency counter and registered busy: busy falls on the commit edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (w_cancel) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (w_launch) begin
      r_cnt  <= w_lat;
      r_busy <= 1'b1;
    end else if (!w_idle) begin
      r_cnt  <= r_cnt - MD_CNT_W'(1);
      r_busy <= (r_cnt != MD_CNT_W'(1));
    end
  end

  // Pending result captured at launch, dropped on cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_dz <= 1'b0;
    end else if (w_cancel) begin
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_dz <= 1'b0;
    end else if (w_launch) begin
      r_pend_hi <= w_res_hi;
      r_pend_lo <= w_res_lo;
      r_pend_dz <= w_div_zero;
    end
  end

  // HI/LO update: commit of a pending result, or a direct MTHI/MTLO in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_commit) begin
      if (!r_pend_dz) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
    end else if (w_accept && bus.op == MD_MTHI) begin
      r_hi <= bus.rs_val;
    end else if (w_accept && bus.op == MD_MTLO) begin
      r_lo <= bus.rs_val;
    end
  end

  assign bus.busy      = r_busy;
  assign bus.stall_req = bus.d_md_use & (r_busy | (bus.start & md_is_muldiv(bus.op)));
  assign bus.hilo_out  = bus.rd_sel ? r_hi : r_lo;
  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;
  assign bus.dbg_state = w_state;

endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- Controls the multiply/divide unit and owns the HI/LO registers for the 5-stage pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E stage and models multi-cycle latency with a busy counter.
- Raises a stall request when a D-stage HI/LO instruction would collide with an in-flight operation.
- Its read value feeds the E-stage HILO result that the E/M pipeline register carries forward.

Parameters:
- MUL_LAT, 5, busy cycles for MULT/MULTU (legal range 1..15).
- DIV_LAT, 10, busy cycles for DIV/DIVU (legal range 1..15).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  E-stage instruction is a valid md-class operation this cycle.
- op  in  3  operation code, MD_* encoding from the package.
- rs_val  in  32  forwarded rs operand.
- rt_val  in  32  forwarded rt operand.
- d_md_use  in  1  D-stage instruction is MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
- rd_sel  in  1  read select: 0 = LO, 1 = HI.
- busy  out  1  multi-cycle operation in flight.
- stall_req  out  1  request to freeze PC and the F/D register and bubble the D/E register.
- hilo_out  out  32  combinational read, HI when rd_sel = 1, else LO.
- hi  out  32  HI register.
- lo  out  32  LO register.
- cancel  in  1  present only with MDU_CANCEL_EN.

Behaviour:
- Reset (asynchronous, any time including mid-operation):
  - busy = 0, counter = 0, HI = 0, LO = 0.
  - Pending result is discarded.
- Two states:
  - IDLE (counter = 0).
  - RUN (counter > 0); busy = (counter != 0), registered.
- IDLE, start with MULT/MULTU/DIV/DIVU:
  - Latch the computed result into pend_hi/pend_lo.
  - Load counter with MUL_LAT or DIV_LAT; busy rises the next cycle.
- RUN:
  - Counter decrements each cycle.
  - On the edge where counter goes 1 -> 0, HI/LO <= pend_hi/pend_lo and busy falls on that same edge.
  - busy is therefore high for exactly LAT cycles.
- MTHI/MTLO in IDLE: HI or LO <= rs_val at the next edge; no busy.
- start while busy: ignored. The pipeline guarantees this never happens via stall_req.
- Unknown op codes: no effect.
- stall_req = d_md_use & (busy | (start & op is MULT/MULTU/DIV/DIVU)). This is combinational.
- MULT: {HI,LO} = signed rs * signed rt (64-bit).
- MULTU: {HI,LO} = unsigned rs * unsigned rt.
- DIV: LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- DIVU: unsigned quotient and remainder.
- Divide by zero: full DIV_LAT busy period runs; HI/LO remain unchanged at commit.
- hilo_out reflects committed HI/LO only; it has no bypass from the pending result.

Optional Feature:
- Macro: MDU_CANCEL_EN.
- Defined:
  - Adds the cancel input, used for exception/flush.
  - cancel = 1 forces counter to 0 and busy to 0 at the next edge, and the pending result is dropped.
  - cancel also blocks a same-cycle start, including MTHI/MTLO.
  - cancel on the commit edge wins, so HI/LO are not updated.
- Undefined: the port is absent; every operation always completes.

Decomposition:
- Package md_pkg:
  - MD_MULT = 0, MD_MULTU = 1, MD_DIV = 2, MD_DIVU = 3, MD_MTHI = 4, MD_MTLO = 5, MD_NOP = 7.
  - Default latency constants and the counter width (4).
- Sub-module md_calc:
  - Purely combinational.
  - Inputs op, rs_val, rt_val; outputs res_hi, res_lo, div_zero.
  - md_ctrl holds only the counter, pending registers and HI/LO.

Test Plan:
- MULT, rs = 0xFFFFFFFE (-2), rt = 3 -> busy high 5 cycles; afterwards HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
- DIVU, rs = 100, rt = 7 -> busy 10 cycles; LO = 14, HI = 2. DIV, rs = -7, rt = 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIV with rt = 0 after MTHI 0x1234 / MTLO 0x5678 -> busy 10 cycles; HI = 0x1234, LO = 0x5678 unchanged.
- d_md_use = 1 during start and each busy cycle -> stall_req = 1. It drops in the cycle after busy falls; d_md_use = 0 while busy -> stall_req = 0.
- rst asserted asynchronously at busy cycle 3 of a MULT -> busy, HI and LO go to 0 immediately; no commit later.
- With MDU_CANCEL_EN: cancel in the last DIV busy cycle -> busy = 0 next edge; HI/LO keep their old values.
